// File: rtl/serdes_pkg.sv
// Shared types and defaults for the serial word deserializer.
package serdes_pkg;

    typedef enum logic {
        DIR_LSB_FIRST = 1'b0,
        DIR_MSB_FIRST = 1'b1
    } dir_e;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } out_state_e;

    localparam int DESER_N_DEFAULT = 8;

endpackage

// File: rtl/deser_out_stage.sv
// Output holding register with EMPTY/HOLD valid/ready control and a sticky overflow flag.
//   state | meaning
//   EMPTY | no word held, out_valid=0
//   HOLD  | word held in out_data, out_valid=1 until consumed
module deser_out_stage
    import serdes_pkg::*;
#(
    parameter int N = DESER_N_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] load_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic         overflow
);

    out_state_e   state_q, state_d;
    logic [N-1:0] data_q, data_d;
    logic         ovf_q, ovf_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = EMPTY;
            data_d  = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (load) begin
                        state_d = HOLD;
                        data_d  = load_data;
                    end
                end
                HOLD: begin
                    if (out_ready && load) begin
                        data_d = load_data;
                    end else if (out_ready) begin
                        state_d = EMPTY;
                    end else if (load) begin
                        // consumer stalled: keep the held word, drop the new one
                        ovf_d = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign out_valid = (state_q == HOLD);
    assign out_data  = data_q;
    assign overflow  = ovf_q;

endmodule

// File: rtl/serial_word_deserializer.sv
// Collects one serial bit per qualified cycle into an N-bit word (LSB- or MSB-first)
// and hands completed words to a valid/ready holding stage.
module serial_word_deserializer
    import serdes_pkg::*;
#(
    parameter int N = DESER_N_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 dir,
    input  logic                 ser_valid,
    input  logic                 ser_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_data,
    output logic [$clog2(N)-1:0] bit_cnt,
    output logic                 overflow
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [N-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    dir_e          dir_q, dir_d;
    dir_e          word_dir;
    logic          word_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            cnt_q <= '0;
            dir_q <= DIR_LSB_FIRST;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        word_done = 1'b0;
        // the first bit of a word uses the live dir; later bits use the latched one
        word_dir  = (cnt_q == '0) ? dir_e'(dir) : dir_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (ser_valid) begin
            dir_d = word_dir;
            if (word_dir == DIR_MSB_FIRST) begin
                acc_d = {acc_q[N-2:0], ser_data};
            end else begin
                acc_d = {ser_data, acc_q[N-1:1]};
            end
            if (cnt_q == CNT_LAST) begin
                cnt_d     = '0;
                word_done = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    deser_out_stage #(.N(N)) u_out_stage (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .load      (word_done),
        .load_data (acc_d),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .overflow  (overflow)
    );

    assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// bit-position word model and a one-slot output holding model.
module tb_serial_word_deserializer;

    localparam int N  = 8;
    localparam int CW = $clog2(N);

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          dir;
    logic          ser_valid;
    logic          ser_data;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic [CW-1:0] bit_cnt;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    serial_word_deserializer #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .dir       (dir),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .bit_cnt   (bit_cnt),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: bits are placed by position within the word.
    int           m_nbits;
    logic [N-1:0] m_part;
    logic         m_dir;
    logic         m_valid;
    logic [N-1:0] m_data;
    logic         m_ovf;
    logic [N-1:0] m_word;
    logic         m_done;
    logic         m_consume;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_nbits = 0; m_part = '0; m_dir = 1'b0;
            m_valid = 1'b0; m_data = '0; m_ovf = 1'b0;
        end else if (clear) begin
            m_nbits = 0; m_part = '0;
            m_valid = 1'b0; m_data = '0; m_ovf = 1'b0;
        end else begin
            m_done = 1'b0;
            if (ser_valid) begin
                if (m_nbits == 0) m_dir = dir;
                if (m_dir) m_part[N-1-m_nbits] = ser_data;
                else       m_part[m_nbits]     = ser_data;
                m_nbits++;
                if (m_nbits == N) begin
                    m_done = 1'b1; m_word = m_part; m_nbits = 0; m_part = '0;
                end
            end
            m_consume = m_valid && out_ready;
            if (m_done) begin
                if (!m_valid || m_consume) begin
                    m_data = m_word; m_valid = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (m_consume) begin
                m_valid = 1'b0;
            end
        end
    end

    bit run_chk = 1'b0;
    always @(negedge clk) begin
        if (run_chk) begin
            chk("cyc_out_valid", out_valid, m_valid);
            chk("cyc_out_data",  out_data,  m_data);
            chk("cyc_bit_cnt",   bit_cnt,   m_nbits);
            chk("cyc_overflow",  overflow,  m_ovf);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_word(input logic [N-1:0] w, input logic d, input logic rdy_last);
        for (int i = 0; i < N; i++) begin
            ser_valid = 1'b1;
            ser_data  = d ? w[N-1-i] : w[i];
            dir       = d;
            if (i == N - 1 && rdy_last) out_ready = 1'b1;
            tick();
        end
        ser_valid = 1'b0;
    endtask

    logic [7:0] b33;

    initial begin
        reset = 1'b0; clear = 1'b0; dir = 1'b0;
        ser_valid = 1'b1; ser_data = 1'b1; out_ready = 1'b0;
        #2;
        run_chk = 1'b1;

        // reset held with ser_valid active
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_valid", out_valid, 0);
            chk("rst_data",  out_data,  8'h00);
            chk("rst_cnt",   bit_cnt,   0);
            chk("rst_ovf",   overflow,  0);
        end
        reset = 1'b1; ser_valid = 1'b0;
        tick();

        // MSB-first 1,0,1,0,0,1,0,1
        out_ready = 1'b1;
        send_word(8'hA5, 1'b1, 1'b0);
        chk("msb_valid", out_valid, 1);
        chk("msb_data",  out_data,  8'hA5);
        chk("model_a5",  m_data,    8'hA5);
        tick();
        chk("msb_one_cycle", out_valid, 0);

        // LSB-first with idle gaps, dir toggled after the 3rd bit
        b33 = 8'b0011_1100;
        for (int i = 0; i < 8; i++) begin
            ser_valid = 1'b1;
            ser_data  = b33[i];
            dir       = (i >= 3);
            tick();
            ser_valid = 1'b0;
            if (i < 7) repeat (1 + (i % 2)) tick();
        end
        chk("lsb_valid", out_valid, 1);
        chk("lsb_data",  out_data,  8'h3C);
        tick();

        // back-pressure and overflow
        out_ready = 1'b0;
        send_word(8'h11, 1'b1, 1'b0);
        chk("bp_first", out_data, 8'h11);
        send_word(8'h22, 1'b1, 1'b0);
        chk("bp_keep",  out_data, 8'h11);
        chk("bp_ovf",   overflow, 1);
        chk("model_ovf", m_ovf,   1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_valid", out_valid, 0);
        chk("clr_ovf",   overflow,  0);
        chk("clr_data",  out_data,  8'h00);

        // consume and complete in the same cycle
        send_word(8'h55, 1'b1, 1'b0);
        chk("sim_hold", out_data, 8'h55);
        send_word(8'h66, 1'b1, 1'b1);
        chk("sim_data",  out_data,  8'h66);
        chk("sim_valid", out_valid, 1);
        chk("sim_ovf",   overflow,  0);
        tick();

        // reset mid-word
        for (int i = 0; i < 4; i++) begin
            ser_valid = 1'b1; ser_data = 1'b1; dir = 1'b0;
            tick();
        end
        ser_valid = 1'b0;
        chk("mid_cnt4", bit_cnt, 4);
        reset = 1'b0;
        #1;
        chk("mid_rst_cnt", bit_cnt, 0);
        tick();
        reset = 1'b1;
        send_word(8'h0F, 1'b1, 1'b0);
        chk("mid_data",  out_data,  8'h0F);
        chk("mid_valid", out_valid, 1);
        tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            ser_valid = ($urandom_range(0, 3) != 0);
            ser_data  = $urandom_range(0, 1);
            dir       = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 63) == 0);
            reset     = ($urandom_range(0, 199) != 0);
            tick();
        end
        reset = 1'b1; clear = 1'b0; ser_valid = 1'b0;
        tick();

        run_chk = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_word_deserializer.md
SERIAL_WORD_DESERIALIZER -- requirements
Module: serial_word_deserializer

Interface
REQ-001 SHALL have parameter: N, 8, word width in bits (N >= 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state is updated on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: clear  input  1  synchronous flush; discards the partial word and the held word, and clears overflow.
REQ-005 SHALL have port: dir  input  1  0 = LSB-first (fills by right shift), 1 = MSB-first (fills by left shift).
REQ-006 SHALL have port: ser_valid  input  1  serial bit qualifier; there is no back-pressure to the serial source.
REQ-007 SHALL have port: ser_data  input  1  serial bit.
REQ-008 SHALL have port: out_valid  output  1  held word available.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts the held word.
REQ-010 SHALL have port: out_data  output  N  assembled word.
REQ-011 SHALL have port: bit_cnt  output  $clog2(N)  number of bits collected in the current word.
REQ-012 SHALL have port: overflow  output  1  sticky flag set when a completed word is dropped.

Function
REQ-013 SHALL accept one bit per cycle with ser_valid=1; cycles with ser_valid=0 SHALL leave the accumulator and bit_cnt unchanged.
REQ-014 SHALL sample dir when a bit is accepted with bit_cnt=0, and SHALL use that sampled value for the whole word; a dir change mid-word SHALL have no effect until the next word.
REQ-015 In LSB-first mode, each accepted bit SHALL shift in at the MSB end (right shift), so that the first bit received ends up in bit 0.
REQ-016 In MSB-first mode, each accepted bit SHALL shift in at the LSB end (left shift), so that the first bit received ends up in bit N-1.
REQ-017 bit_cnt SHALL increment on each accepted bit and SHALL wrap from N-1 to 0 when the Nth bit is accepted (word complete).
REQ-018 The completed word SHALL transfer to out_data with out_valid=1 on the clock edge that accepts the Nth bit, i.e. visible one cycle after the Nth bit is presented.
REQ-019 Handshake: the held word is consumed on a cycle with out_valid=1 and out_ready=1; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 Output state machine states: EMPTY (out_valid=0) and HOLD (out_valid=1).
REQ-021 EMPTY->HOLD SHALL occur on word complete.
REQ-022 HOLD->EMPTY SHALL occur on consume with no word completing in the same cycle.
REQ-023 HOLD->HOLD SHALL occur on consume with a word completing in the same cycle, loading the new word with no bubble.
REQ-024 When a word completes in HOLD without a consume, the new word SHALL be dropped, the held word kept, and overflow set.
REQ-025 clear SHALL take priority over ser_valid and out_ready: next state EMPTY, bit_cnt=0, accumulator=0, out_data=0, overflow=0.
REQ-026 overflow SHALL clear only by clear or reset.

Reset
REQ-027 reset=0 SHALL immediately force out_valid=0, out_data=0, bit_cnt=0, overflow=0, accumulator=0, sampled dir=0, state EMPTY, regardless of clk.
REQ-028 A reset mid-word SHALL discard the partial bits; the first accepted bit after release SHALL start a new word.

Structure
REQ-029 Package serdes_pkg SHALL hold the dir_e typedef (DIR_LSB_FIRST=0, DIR_MSB_FIRST=1), the out_state_e typedef (EMPTY, HOLD) and the default width constant DESER_N_DEFAULT=8.
REQ-030 The output holding register and its EMPTY/HOLD control SHALL be a single sub-module, deser_out_stage; the accumulator and bit counter SHALL stay in the top module.

Verification
REQ-031 Reset: hold reset=0 for 3 cycles while driving ser_valid=1 -> out_valid=0, out_data=0x00, bit_cnt=0, overflow=0 throughout.
REQ-032 MSB-first: dir=1, out_ready=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles -> out_data=0xA5, out_valid high exactly 1 cycle, starting the cycle after the 8th bit.
REQ-033 LSB-first with gaps: dir=0, bits 0,0,1,1,1,1,0,0 with ser_valid=0 idle cycles inserted, and dir toggled after the 3rd bit -> out_data=0x3C.
REQ-034 Back-pressure: out_ready=0, send 0x11 then 0x22 (MSB-first) -> out_data stays 0x11 and overflow=1; pulse clear -> out_valid=0, overflow=0.
REQ-035 Simultaneous: hold 0x55, complete 0x66 in the same cycle as out_ready=1 -> next cycle out_data=0x66, out_valid stays 1, overflow=0.
REQ-036 Reset mid-word: 4 bits in, then reset pulse -> bit_cnt=0; next 8 bits of 0x0F MSB-first -> out_data=0x0F.
